// File: rtl/mmm_pkg.sv
// ---------------------------------------------------------------------------
// mmm_pkg : shared widths, predictor record types and counter helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mmm_pkg;

   localparam int XLEN                = 32;
   localparam int BHT_ENTRIES_DEFAULT = 64;
   localparam int BTB_ENTRIES_DEFAULT = 64;

   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] target;
   } prediction_t;

   typedef struct packed {
      logic            valid;
      logic            mispredict;
      logic            taken;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
   } resolution_t;

   localparam logic [1:0] CNT_STRONG_NT = 2'b00;
   localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
   localparam logic [1:0] CNT_STRONG_T  = 2'b11;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != CNT_STRONG_T) nxt = cnt + 2'd1;
      end else begin
         if (cnt != CNT_STRONG_NT) nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_prediction_unit_btb.sv
// ---------------------------------------------------------------------------
// btb : direct-mapped branch target buffer, combinational read, sync write
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btb #(
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 24,
   parameter int DATA_W  = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [$clog2(ENTRIES)-1:0] rd_idx,
   input  logic [TAG_W-1:0]           rd_tag,
   output logic                       rd_hit,
   output logic [DATA_W-1:0]          rd_target,
   input  logic                       wr_en,
   input  logic [$clog2(ENTRIES)-1:0] wr_idx,
   input  logic [TAG_W-1:0]           wr_tag,
   input  logic [DATA_W-1:0]          wr_target
);

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tags    [ENTRIES];
   logic [DATA_W-1:0]  targets [ENTRIES];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Tag/target storage carries no reset; valid alone qualifies a hit.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tags[wr_idx]    <= wr_tag;
         targets[wr_idx] <= wr_target;
      end
   end

   assign rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
   assign rd_target = targets[rd_idx];

endmodule

`default_nettype wire

// File: rtl/branch_prediction_unit.sv
// ---------------------------------------------------------------------------
// branch_prediction_unit : bimodal BHT + direct-mapped BTB fetch predictor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_prediction_unit
   import mmm_pkg::*;
#(
   parameter int BHT_ENTRIES = BHT_ENTRIES_DEFAULT,
   parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   input  resolution_t     res_i,
   output prediction_t     pred_o
);

   localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
   localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W     = XLEN - BTB_IDX_W - 2;

   logic [1:0]           bht [BHT_ENTRIES];
   logic [BHT_IDX_W-1:0] lkp_bht_idx;
   logic [BHT_IDX_W-1:0] upd_bht_idx;
   logic [BTB_IDX_W-1:0] lkp_btb_idx;
   logic [BTB_IDX_W-1:0] upd_btb_idx;
   logic [TAG_W-1:0]     lkp_tag;
   logic [TAG_W-1:0]     upd_tag;
   logic                 btb_hit;
   logic [XLEN-1:0]      btb_target;
   logic                 pred_taken;
   logic [XLEN-1:0]      pred_target;
   logic                 btb_wr_en;
   logic                 unused_res;

   assign lkp_bht_idx = pc_i[BHT_IDX_W+1:2];
   assign upd_bht_idx = res_i.pc[BHT_IDX_W+1:2];
   assign lkp_btb_idx = pc_i[BTB_IDX_W+1:2];
   assign upd_btb_idx = res_i.pc[BTB_IDX_W+1:2];
   assign lkp_tag     = pc_i[XLEN-1:BTB_IDX_W+2];
   assign upd_tag     = res_i.pc[XLEN-1:BTB_IDX_W+2];
   assign btb_wr_en   = res_i.valid & res_i.taken;

   // Training is identical for mispredicts; the flag is carried for visibility only.
   assign unused_res  = ^{res_i.mispredict, res_i.pc[1:0]};

   btb #(
      .ENTRIES (BTB_ENTRIES),
      .TAG_W   (TAG_W),
      .DATA_W  (XLEN)
   ) u_btb (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .rd_idx    (lkp_btb_idx),
      .rd_tag    (lkp_tag),
      .rd_hit    (btb_hit),
      .rd_target (btb_target),
      .wr_en     (btb_wr_en),
      .wr_idx    (upd_btb_idx),
      .wr_tag    (upd_tag),
      .wr_target (res_i.target)
   );

   // Reads see pre-update table state, so a same-cycle train is visible next lookup.
   assign pred_taken  = btb_hit & bht[lkp_bht_idx][1];
   assign pred_target = pred_taken ? btb_target : (pc_i + XLEN'(4));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pred_o <= '0;
      end else if (flush_i) begin
         pred_o <= '0;
      end else begin
         pred_o.taken  <= pred_taken;
         pred_o.target <= pred_target;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= CNT_WEAK_NT;
         end
      end else if (res_i.valid) begin
         bht[upd_bht_idx] <= sat_update(bht[upd_bht_idx], res_i.taken);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_prediction_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_prediction_unit : directed + random checks against an array model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_prediction_unit;
   import mmm_pkg::*;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic [XLEN-1:0] pc    = '0;
   resolution_t     res   = '0;
   prediction_t     pred;

   branch_prediction_unit dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .flush_i (flush),
      .pc_i    (pc),
      .res_i   (res),
      .pred_o  (pred)
   );

   always #5 clk = ~clk;

   int              cnt   [64];
   bit              bvalid[64];
   logic [XLEN-1:0] btag  [64];
   logic [XLEN-1:0] btgt  [64];
   logic            m_taken;
   logic [XLEN-1:0] m_target;
   int vectors     = 0;
   int miscompares = 0;

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         cnt[i]    = 1;
         bvalid[i] = 1'b0;
      end
      m_taken  = 1'b0;
      m_target = '0;
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (rst_n) begin
         int bi;
         int ri;
         bi = int'((pc >> 2) % 64);
         if (flush) begin
            m_taken  = 1'b0;
            m_target = '0;
         end else begin
            m_taken  = bvalid[bi] && (btag[bi] == (pc >> 8)) && (cnt[bi] >= 2);
            m_target = m_taken ? btgt[bi] : pc + 32'd4;
         end
         if (res.valid) begin
            ri = int'((res.pc >> 2) % 64);
            if (res.taken) begin
               cnt[ri]    = (cnt[ri] == 3) ? 3 : cnt[ri] + 1;
               bvalid[ri] = 1'b1;
               btag[ri]   = res.pc >> 8;
               btgt[ri]   = res.target;
            end else begin
               cnt[ri] = (cnt[ri] == 0) ? 0 : cnt[ri] - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         vectors++;
         if (pred.taken !== m_taken || pred.target !== m_target) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t actual {%0b,%h} required {%0b,%h}",
                     $time, pred.taken, pred.target, m_taken, m_target);
         end
      end
   end

   task automatic check_now(input string name, input logic t, input logic [XLEN-1:0] tg);
      vectors++;
      if (pred.taken !== t || pred.target !== tg) begin
         miscompares++;
         $display("FAIL %s actual {%0b,%h} required {%0b,%h}", name, pred.taken, pred.target, t, tg);
      end
   endtask

   task automatic check_lit(input string name, input logic t, input logic [XLEN-1:0] tg);
      @(negedge clk);
      check_now(name, t, tg);
   endtask

   task automatic cyc(input logic [XLEN-1:0] p, input logic rv, input logic rt,
                      input logic [XLEN-1:0] rpc, input logic [XLEN-1:0] rtg, input logic fl);
      pc             = p;
      res.valid      = rv;
      res.mispredict = rv & 1'($urandom_range(0, 1));
      res.taken      = rt;
      res.pc         = rpc;
      res.target     = rtg;
      flush          = fl;
      @(posedge clk);
      #1;
      res.valid = 1'b0;
      flush     = 1'b0;
   endtask

   logic [XLEN-1:0] rp;

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_now("reset_state", 1'b0, 32'h0);
      rst_n = 1'b1;

      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("cold_lookup", 1'b0, 32'h104);

      cyc(32'h100, 1, 1, 32'h100, 32'h80, 0);
      check_lit("same_cycle_conflict", 1'b0, 32'h104);
      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("trained_taken", 1'b1, 32'h80);
      cyc(32'h104, 0, 0, 0, 0, 0);
      check_lit("neighbour_nt", 1'b0, 32'h108);

      repeat (5) cyc(32'h104, 1, 1, 32'h100, 32'h80, 0);
      cyc(32'h104, 1, 0, 32'h100, 32'h0, 0);
      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("sat_high_then_nt", 1'b1, 32'h80);
      repeat (3) cyc(32'h104, 1, 0, 32'h100, 32'h0, 0);
      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("sat_low", 1'b0, 32'h104);
      cyc(32'h104, 1, 1, 32'h100, 32'h80, 0);
      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("weak_nt_after_one_t", 1'b0, 32'h104);

      repeat (2) cyc(32'h104, 1, 1, 32'h100, 32'h80, 0);
      cyc(32'h200, 0, 0, 0, 0, 0);
      check_lit("alias_tag_miss", 1'b0, 32'h204);
      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("alias_owner_hit", 1'b1, 32'h80);

      cyc(32'h104, 1, 0, 32'h100, 32'h0, 0);
      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("pre_flush_taken", 1'b1, 32'h80);
      cyc(32'h100, 1, 0, 32'h100, 32'h0, 1);
      check_lit("flush_kills", 1'b0, 32'h0);
      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("flush_still_trains", 1'b0, 32'h104);

      repeat (2) cyc(32'h104, 1, 1, 32'h100, 32'h80, 0);
      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("pre_reset_taken", 1'b1, 32'h80);
      #2 rst_n = 1'b0;
      #1 check_now("async_reset_now", 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(32'h100, 0, 0, 0, 0, 0);
      check_lit("post_reset_nt", 1'b0, 32'h104);

      cyc(32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      check_lit("pc_wrap", 1'b0, 32'h0);

      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         if (n == 700) begin
            rst_n = 1'b0;
         end else begin
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 19) == 0) begin
            pc = $urandom();
         end else begin
            pc = (XLEN'($urandom_range(0, 3)) << 8) | (XLEN'($urandom_range(0, 7)) << 2)
               | XLEN'($urandom_range(0, 3));
         end
         rp = (XLEN'($urandom_range(0, 3)) << 8) | (XLEN'($urandom_range(0, 7)) << 2)
            | XLEN'($urandom_range(0, 3));
         res.valid      = 1'($urandom_range(0, 1));
         res.mispredict = 1'($urandom_range(0, 1));
         res.taken      = 1'($urandom_range(0, 1));
         res.pc         = rp;
         res.target     = $urandom();
         flush          = ($urandom_range(0, 19) == 0);
      end
      @(negedge clk);
      res.valid = 1'b0;
      flush     = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
